// File: rtl/upload_pkg.sv
// Shared definitions for the upload path: frame sync bytes, packer states and
// the source IDs used by command_processor when tagging uploaded bytes.
package upload_pkg;

  localparam logic [7:0] HDR0_DEFAULT   = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT   = 8'h55;

  localparam logic [7:0] SRC_I2C_CONFIG = 8'h04;
  localparam logic [7:0] SRC_I2C_WRITE  = 8'h05;
  localparam logic [7:0] SRC_I2C_READ   = 8'h06;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HDR0,
    ST_HDR1,
    ST_SRC,
    ST_LENH,
    ST_LENL,
    ST_PAYLOAD,
    ST_CKSUM
  } state_e;

endpackage

// File: rtl/upload_fifo.sv
// Single-clock payload FIFO; the head entry is visible on rd_data_o so the
// framer can present it in the same cycle it pops.
module upload_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_q <= count_q + CW'(1);
      else if (do_rd && !do_wr) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/upload_packer.sv
// Collects per-byte uploads into bursts and emits each burst as a framed
// packet: HDR0 HDR1 SRC LEN_H LEN_L payload CKSUM.
module upload_packer
  import upload_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  HDR0           = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1           = HDR1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic [7:0]       cur_src_q, cur_src_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [15:0]      len_q, len_d;
  logic [7:0]       cksum_q, cksum_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             ready_q, ready_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic [7:0]       pend_src_q, pend_src_d;
  logic             overflow_q, overflow_d;

  logic             push, pop, flush, drain;
  logic [7:0]       push_data;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   count_after;
  logic             hs, src_change, accept, to_pend;
  logic [7:0]       cksum_sum;
  logic             unused_req;

  assign unused_req = upload_req;

  upload_fifo #(
    .DEPTH (MAX_PAYLOAD),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign hs         = tx_valid_q && tx_ready;
  assign cksum_sum  = cksum_q + tx_data_q;
  assign src_change = upload_valid && ready_q && (state_q == ST_COLLECT) &&
                      (upload_source != cur_src_q);
  assign accept     = upload_valid && ready_q && !src_change;
  // A source change ends the burst; that byte waits in pend for the next one.
  assign to_pend    = (upload_valid && !ready_q) || src_change;

  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    timer_d      = timer_q;
    len_d        = len_q;
    cksum_d      = cksum_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_src_d   = pend_src_q;
    overflow_d   = overflow_q;
    push         = 1'b0;
    push_data    = upload_data;
    pop          = 1'b0;
    flush        = 1'b0;
    drain        = 1'b0;

    if (to_pend) begin
      if (pend_valid_q) begin
        overflow_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_data_d  = upload_data;
        pend_src_d   = upload_source;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q && !fifo_full) begin
          drain = 1'b1;
        end else if (accept) begin
          push      = 1'b1;
          cur_src_d = upload_source;
          timer_d   = '0;
          state_d   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          push    = 1'b1;
          timer_d = '0;
          if (fifo_count == CNT_W'(MAX_PAYLOAD - 1)) flush = 1'b1;
        end else if (src_change) begin
          flush = 1'b1;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          flush = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_HDR0: if (hs) begin
        tx_data_d = HDR1;
        state_d   = ST_HDR1;
      end
      ST_HDR1: if (hs) begin
        tx_data_d = cur_src_q;
        state_d   = ST_SRC;
      end
      ST_SRC: if (hs) begin
        cksum_d   = cksum_sum;
        tx_data_d = len_q[15:8];
        state_d   = ST_LENH;
      end
      ST_LENH: if (hs) begin
        cksum_d   = cksum_sum;
        tx_data_d = len_q[7:0];
        state_d   = ST_LENL;
      end
      ST_LENL: if (hs) begin
        cksum_d   = cksum_sum;
        tx_data_d = fifo_rd_data;
        pop       = 1'b1;
        state_d   = ST_PAYLOAD;
      end
      // The FIFO holds exactly LEN bytes at flush, so empty marks the last one.
      ST_PAYLOAD: if (hs) begin
        cksum_d = cksum_sum;
        if (fifo_empty) begin
          tx_data_d = cksum_sum;
          state_d   = ST_CKSUM;
        end else begin
          tx_data_d = fifo_rd_data;
          pop       = 1'b1;
        end
      end
      ST_CKSUM: if (hs) begin
        tx_valid_d = 1'b0;
        if (pend_valid_q) drain = 1'b1;
        else              state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (drain) begin
      push         = 1'b1;
      push_data    = pend_data_q;
      cur_src_d    = pend_src_q;
      pend_valid_d = 1'b0;
      timer_d      = '0;
      state_d      = ST_COLLECT;
    end

    if (flush) begin
      state_d    = ST_HDR0;
      tx_valid_d = 1'b1;
      tx_data_d  = HDR0;
      cksum_d    = '0;
      len_d      = 16'(fifo_count) + 16'(push);
    end

    count_after = {1'b0, fifo_count} + {{CNT_W{1'b0}}, push};
    ready_d     = ((state_d == ST_IDLE) || (state_d == ST_COLLECT)) &&
                  !pend_valid_d && (count_after < (CNT_W + 1)'(MAX_PAYLOAD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_src_q    <= '0;
      timer_q      <= '0;
      len_q        <= '0;
      cksum_q      <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      ready_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_src_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      timer_q      <= timer_d;
      len_q        <= len_d;
      cksum_q      <= cksum_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      ready_q      <= ready_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_src_q   <= pend_src_d;
      overflow_q   <= overflow_d;
    end
  end

  assign upload_ready = ready_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty || pend_valid_q;

endmodule

// File: tb/tb_upload_packer.sv
// Directed bench for upload_packer: framing, flush triggers, back-pressure,
// pend/overflow handling and mid-frame reset.
module tb_upload_packer;
  import upload_pkg::*;

  localparam int TIMEOUT = 1000;
  localparam int MAXP    = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upload_req = 1'b0;
  logic [7:0] upload_data = 8'h00;
  logic [7:0] upload_source = 8'h00;
  logic       upload_valid = 1'b0;
  logic       upload_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       overflow;

  logic [7:0] cap[$];
  int stall_viol = 0;
  int stall_cycles = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  upload_packer #(
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .upload_req    (upload_req),
    .upload_data   (upload_data),
    .upload_source (upload_source),
    .upload_valid  (upload_valid),
    .upload_ready  (upload_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .overflow      (overflow)
  );

  // Records every byte that will transfer on the coming edge and counts
  // any change of tx_data/tx_valid across a stalled cycle.
  initial begin : monitor
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_viol++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) cap.push_back(tx_data);
        prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
        prev_data  = tx_data;
        if (prev_stall) stall_cycles++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic [7:0] s);
    @(negedge clk);
    upload_data   = d;
    upload_source = s;
    upload_valid  = 1'b1;
    upload_req    = 1'b1;
    @(negedge clk);
    upload_valid  = 1'b0;
    upload_req    = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (cap.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (upload_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", upload_ready); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %02h want 00", tx_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (upload_ready !== 1'b1) $display("FAIL ready_after_release: got %b want 1", upload_ready); else pass_cnt++;
    $display("test_reset done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_timeout();
    logic [7:0] exp[$];
    int cyc;
    bit ok;
    cap.delete();
    tx_ready = 1'b1;
    exp = {8'hAA, 8'h55, 8'h06, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6F};
    send_byte(8'h11, SRC_I2C_READ);
    repeat (19) @(negedge clk);
    send_byte(8'h22, SRC_I2C_READ);
    repeat (19) @(negedge clk);
    send_byte(8'h33, SRC_I2C_READ);
    cyc = 0;
    while (tx_valid !== 1'b1 && cyc < 2 * TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    total_cnt++; if (cyc != TIMEOUT) $display("FAIL timeout_latency: got %0d want %0d", cyc, TIMEOUT); else pass_cnt++;
    wait_bytes(9, 50, ok);
    total_cnt++; if (!ok) $display("FAIL timeout_frame_arrival: got %0d bytes want 9", cap.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL timeout_busy_in_cksum: got %b want 1", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL timeout_busy_after: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL timeout_valid_after: got %b want 0", tx_valid); else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      total_cnt++;
      if (i >= cap.size() || cap[i] !== exp[i])
        $display("FAIL timeout_frame byte %0d: got %02h want %02h", i, (i < cap.size()) ? cap[i] : 8'h00, exp[i]);
      else pass_cnt++;
    end
    total_cnt++; if (cap.size() != exp.size()) $display("FAIL timeout_frame_len: got %0d want %0d", cap.size(), exp.size()); else pass_cnt++;
    $display("test_timeout done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_max_payload();
    logic [7:0] exp[$];
    int not_ready;
    bit ok;
    cap.delete();
    tx_ready  = 1'b1;
    not_ready = 0;
    exp = {8'hAA, 8'h55, 8'h06, 8'h00, 8'h40};
    for (int i = 0; i < MAXP; i++) exp.push_back(8'(i));
    exp.push_back(8'h26);
    for (int i = 0; i < MAXP; i++) begin
      @(negedge clk);
      if (upload_ready !== 1'b1) not_ready++;
      upload_data   = 8'(i);
      upload_source = SRC_I2C_READ;
      upload_valid  = 1'b1;
    end
    @(negedge clk);
    upload_valid = 1'b0;
    total_cnt++; if (not_ready != 0) $display("FAIL max_ready_during_fill: got %0d low cycles want 0", not_ready); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b1) $display("FAIL max_immediate_flush: got %b want 1", tx_valid); else pass_cnt++;
    total_cnt++; if (upload_ready !== 1'b0) $display("FAIL max_ready_in_emit: got %b want 0", upload_ready); else pass_cnt++;
    wait_bytes(MAXP + 6, 200, ok);
    total_cnt++; if (!ok) $display("FAIL max_frame_arrival: got %0d bytes want %0d", cap.size(), MAXP + 6); else pass_cnt++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < exp.size(); i++) begin
      total_cnt++;
      if (i >= cap.size() || cap[i] !== exp[i])
        $display("FAIL max_frame byte %0d: got %02h want %02h", i, (i < cap.size()) ? cap[i] : 8'h00, exp[i]);
      else pass_cnt++;
    end
    total_cnt++; if (cap.size() != exp.size()) $display("FAIL max_frame_len: got %0d want %0d", cap.size(), exp.size()); else pass_cnt++;
    $display("test_max_payload done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_source_change();
    logic [7:0] exp[$];
    bit ok;
    cap.delete();
    tx_ready = 1'b1;
    exp = {8'hAA, 8'h55, 8'h06, 8'h00, 8'h01, 8'hA5, 8'hAC,
           8'hAA, 8'h55, 8'h05, 8'h00, 8'h01, 8'h5A, 8'h60};
    send_byte(8'hA5, SRC_I2C_READ);
    repeat (4) @(negedge clk);
    send_byte(8'h5A, SRC_I2C_WRITE);
    total_cnt++; if (tx_valid !== 1'b1) $display("FAIL srcchg_immediate_flush: got %b want 1", tx_valid); else pass_cnt++;
    wait_bytes(14, TIMEOUT + 200, ok);
    total_cnt++; if (!ok) $display("FAIL srcchg_arrival: got %0d bytes want 14", cap.size()); else pass_cnt++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < exp.size(); i++) begin
      total_cnt++;
      if (i >= cap.size() || cap[i] !== exp[i])
        $display("FAIL srcchg_frame byte %0d: got %02h want %02h", i, (i < cap.size()) ? cap[i] : 8'h00, exp[i]);
      else pass_cnt++;
    end
    total_cnt++; if (overflow !== 1'b0) $display("FAIL srcchg_overflow: got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL srcchg_busy_after: got %b want 0", busy); else pass_cnt++;
    $display("test_source_change done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    bit ok;
    cap.delete();
    stall_viol   = 0;
    stall_cycles = 0;
    tx_ready     = 1'b1;
    exp = {8'hAA, 8'h55, 8'h04, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h67};
    send_byte(8'h10, SRC_I2C_CONFIG);
    send_byte(8'h20, SRC_I2C_CONFIG);
    send_byte(8'h30, SRC_I2C_CONFIG);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT + 400; i++) begin
      @(negedge clk);
      tx_ready = 1'($urandom_range(0, 1));
      #2;
      if (cap.size() >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (!ok) $display("FAIL bp_arrival: got %0d bytes want 9", cap.size()); else pass_cnt++;
    total_cnt++; if (stall_viol != 0) $display("FAIL bp_stable_during_stall: got %0d changes want 0", stall_viol); else pass_cnt++;
    total_cnt++; if (stall_cycles == 0) $display("FAIL bp_stall_exercised: got %0d stalls want >0", stall_cycles); else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      total_cnt++;
      if (i >= cap.size() || cap[i] !== exp[i])
        $display("FAIL bp_frame byte %0d: got %02h want %02h", i, (i < cap.size()) ? cap[i] : 8'h00, exp[i]);
      else pass_cnt++;
    end
    total_cnt++; if (cap.size() != exp.size()) $display("FAIL bp_frame_len: got %0d want %0d", cap.size(), exp.size()); else pass_cnt++;
    $display("test_backpressure done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    int cyc;
    bit ok;
    cap.delete();
    tx_ready = 1'b0;
    exp = {8'hAA, 8'h55, 8'h06, 8'h00, 8'h01, 8'hB1, 8'hB8,
           8'hAA, 8'h55, 8'h06, 8'h00, 8'h01, 8'hC1, 8'hC8};
    send_byte(8'hB1, SRC_I2C_READ);
    cyc = 0;
    while (tx_valid !== 1'b1 && cyc < TIMEOUT + 100) begin
      @(negedge clk);
      cyc++;
    end
    total_cnt++; if (tx_valid !== 1'b1) $display("FAIL ovf_frame_start: got %b want 1", tx_valid); else pass_cnt++;
    total_cnt++; if (upload_ready !== 1'b0) $display("FAIL ovf_ready_in_emit: got %b want 0", upload_ready); else pass_cnt++;
    send_byte(8'hC1, SRC_I2C_READ);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_pend_no_loss: got %b want 0", overflow); else pass_cnt++;
    send_byte(8'hC2, SRC_I2C_READ);
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set_on_drop: got %b want 1", overflow); else pass_cnt++;
    tx_ready = 1'b1;
    wait_bytes(14, TIMEOUT + 200, ok);
    total_cnt++; if (!ok) $display("FAIL ovf_arrival: got %0d bytes want 14", cap.size()); else pass_cnt++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < exp.size(); i++) begin
      total_cnt++;
      if (i >= cap.size() || cap[i] !== exp[i])
        $display("FAIL ovf_frame byte %0d: got %02h want %02h", i, (i < cap.size()) ? cap[i] : 8'h00, exp[i]);
      else pass_cnt++;
    end
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else pass_cnt++;
    $display("test_overflow done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp[$];
    bit ok;
    cap.delete();
    tx_ready = 1'b1;
    exp = {8'hAA, 8'h55, 8'h04, 8'h00, 8'h01, 8'h7E, 8'h83};
    send_byte(8'h01, SRC_I2C_READ);
    send_byte(8'h02, SRC_I2C_READ);
    send_byte(8'h03, SRC_I2C_READ);
    wait_bytes(6, TIMEOUT + 100, ok);
    total_cnt++; if (!ok || tx_valid !== 1'b1) $display("FAIL midrst_in_payload: got valid=%b bytes=%0d want 1/6", tx_valid, cap.size()); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL midrst_valid_async: got %b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL midrst_overflow_cleared: got %b want 0", overflow); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cap.delete();
    send_byte(8'h7E, SRC_I2C_CONFIG);
    wait_bytes(7, TIMEOUT + 100, ok);
    total_cnt++; if (!ok) $display("FAIL midrst_arrival: got %0d bytes want 7", cap.size()); else pass_cnt++;
    repeat (5) @(negedge clk);
    for (int i = 0; i < exp.size(); i++) begin
      total_cnt++;
      if (i >= cap.size() || cap[i] !== exp[i])
        $display("FAIL midrst_frame byte %0d: got %02h want %02h", i, (i < cap.size()) ? cap[i] : 8'h00, exp[i]);
      else pass_cnt++;
    end
    total_cnt++; if (cap.size() != exp.size()) $display("FAIL midrst_frame_len: got %0d want %0d", cap.size(), exp.size()); else pass_cnt++;
    $display("test_reset_midframe done: %0d/%0d", pass_cnt, total_cnt);
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_max_payload();
    test_source_change();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
